// File: rtl/counter_load_sequencer.sv
`timescale 1ns/1ps
// Request FIFO + IDLE/LOAD/HOLD sequencer that drives counter_load's load/data_in pair.
// Optional synchronous flush input `abort` is enabled by defining LOAD_SEQ_ABORT_EN.
module counter_load_sequencer #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef LOAD_SEQ_ABORT_EN
  input  logic                         abort,
`endif
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [WIDTH-1:0]             req_value,
  input  logic [HOLD_W-1:0]            req_hold,
  output logic                         load,
  output logic [WIDTH-1:0]             data_in,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int EW = WIDTH + HOLD_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     count_q, count_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              load_q, load_d;
  logic              busy_q, busy_d;
  logic [EW-1:0]     mem_q [DEPTH];

  logic              abort_w;
  logic              full, empty, push, pop, decide;
  logic [EW-1:0]     head;
  logic [WIDTH-1:0]  head_val;
  logic [HOLD_W-1:0] head_hold;

`ifdef LOAD_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign full      = (count_q == LW'(DEPTH));
  assign empty     = (count_q == '0);
  assign req_ready = !full && !abort_w;
  assign push      = req_valid && req_ready;
  assign head      = mem_q[rd_ptr_q];
  assign head_val  = head[EW-1:HOLD_W];
  assign head_hold = head[HOLD_W-1:0];

  // The hold counter counts down to 1 in HOLD, so HOLD lasts exactly `hold` cycles.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    data_d  = data_q;
    pop     = 1'b0;
    decide  = 1'b0;
    case (state_q)
      S_IDLE: decide = 1'b1;
      S_LOAD: begin
        if (hold_q == '0) decide = 1'b1;
        else              state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hold_q == HOLD_W'(1)) decide = 1'b1;
        else                      hold_d = hold_q - HOLD_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (decide) begin
      if (!empty) begin
        pop     = 1'b1;
        state_d = S_LOAD;
        hold_d  = head_hold;
        data_d  = head_val;
      end else begin
        state_d = S_IDLE;
      end
    end
    if (abort_w) begin
      pop     = 1'b0;
      state_d = S_IDLE;
      hold_d  = hold_q;
      data_d  = data_q;
    end
    load_d = (state_d == S_LOAD);
    if (abort_w) begin
      count_d = '0;
    end else begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + LW'(1);
      else if (pop && !push) count_d = count_q - LW'(1);
    end
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      data_q   <= '0;
      load_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      if (abort_w) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage carries no reset; occupancy alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_value, req_hold};
  end

  assign load    = load_q;
  assign data_in = data_q;
  assign busy    = busy_q;
  assign level   = count_q;

endmodule

// File: tb/tb_counter_load_sequencer.sv
`timescale 1ns/1ps
// Randomized bench for counter_load_sequencer against a queue/timestamp reference model.
module tb_counter_load_sequencer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       abort = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_value = '0;
  logic [3:0] req_hold = '0;
  logic       req_ready, load, busy;
  logic [3:0] data_in;
  logic [2:0] level;

  counter_load_sequencer #(.WIDTH(4), .DEPTH(DEPTH), .HOLD_W(4)) dut (
    .clk(clk),
    .rst(rst),
`ifdef LOAD_SEQ_ABORT_EN
    .abort(abort),
`endif
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_value(req_value),
    .req_hold(req_hold),
    .load(load),
    .data_in(data_in),
    .busy(busy),
    .level(level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue; the pulse timeline is described by the last
  // pop edge index P and its hold H. Cycle c is a load if c==P, a gap if P<c<=P+H.
  int q_val[$];
  int q_hold[$];
  int c = 0;
  int P = -100;
  int H = 0;
  int m_data = 0;
  bit m_load = 0;

  always @(posedge clk or negedge rst) begin
    int sz;
    if (!rst) begin
      q_val.delete(); q_hold.delete();
      c = 0; P = -100; H = 0; m_data = 0; m_load = 0;
    end else begin
      c++;
      sz = q_val.size();
      m_load = 0;
      if (abort) begin
        q_val.delete(); q_hold.delete();
        P = -100; H = 0;
      end else begin
        if ((c >= P + H + 1) && sz > 0) begin
          m_data = q_val.pop_front();
          H      = q_hold.pop_front();
          P      = c;
          m_load = 1;
        end
        if (req_valid && sz < DEPTH) begin
          q_val.push_back(int'(req_value));
          q_hold.push_back(int'(req_hold));
        end
      end
    end
  end

  int seen[$];
  int nloads = 0;
  bit saw_full = 0;

  always @(posedge clk) begin
    #2;
    chk("load", load, m_load);
    chk("data_in", data_in, m_data);
    chk("level", level, q_val.size());
    chk("busy", busy, ((c <= P + H) || (q_val.size() > 0)) ? 1 : 0);
    chk("req_ready", req_ready, ((q_val.size() < DEPTH) && !abort) ? 1 : 0);
    if (rst && load) begin
      seen.push_back(int'(data_in));
      nloads++;
    end
    if (rst && level == 3'd4) saw_full = 1;
  end

  task automatic drive_req(input int v, input int h);
    int  n;
    bit  acc;
    n = 0; acc = 0;
    @(negedge clk);
    req_valid = 1'b1; req_value = 4'(v); req_hold = 4'(h);
    while (!acc && n < 200) begin
      acc = req_ready;
      @(posedge clk);
      n++;
      if (!acc) @(negedge clk);
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL push_timeout: got no accept expected accept of %0d", v);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
  endtask

  initial begin
    int n0;
    int n;
    // Reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_load", load, 0);
    chk("rst_data", data_in, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);

    // Single request: load high exactly E1..E2
    drive_req(9, 0);
    #3;
    chk("single_e0_level", level, 1);
    chk("single_e0_load", load, 0);
    @(negedge clk); req_valid = 1'b0;
    @(posedge clk); #3;
    chk("single_e1_load", load, 1);
    chk("single_e1_data", data_in, 9);
    @(posedge clk); #3;
    chk("single_e2_load", load, 0);
    chk("single_e2_data", data_in, 9);
    chk("single_e2_busy", busy, 0);

    // Hold gap: pattern 1,0,0,1
    drive_req(3, 2);
    drive_req(7, 0);
    #3;
    chk("gap_c0_load", load, 1);
    chk("gap_c0_data", data_in, 3);
    @(negedge clk); req_valid = 1'b0;
    @(posedge clk); #3;
    chk("gap_c1_load", load, 0);
    @(posedge clk); #3;
    chk("gap_c2_load", load, 0);
    @(posedge clk); #3;
    chk("gap_c3_load", load, 1);
    chk("gap_c3_data", data_in, 7);
    wait_idle();

    // Full FIFO and pointer wrap
    seen.delete();
    saw_full = 0;
    for (int i = 0; i < 6; i++) drive_req(10 + i, 3);
    @(negedge clk); req_valid = 1'b0;
    wait_idle();
    chk("wrap_saw_full", saw_full, 1);
    chk("wrap_count", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) chk("wrap_order", seen[i], 10 + i);

    // Reset during LOAD with two entries queued
    for (int i = 1; i <= 4; i++) drive_req(i, 2);
    @(negedge clk); req_valid = 1'b0;
    n = 0;
    while (!(load && level == 3'd2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reached", (load && level == 3'd2) ? 1 : 0, 1);
    rst = 1'b0;
    #1;
    chk("midrst_load", load, 0);
    chk("midrst_level", level, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", data_in, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    n0 = nloads;
    repeat (10) @(posedge clk);
    #3;
    chk("midrst_noloads", nloads, n0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 2) != 0);
      req_value = 4'($urandom);
      req_hold  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 6)) : 4'(0);
`ifdef LOAD_SEQ_ABORT_EN
      abort = ($urandom_range(0, 39) == 0);
`endif
    end
    @(negedge clk); req_valid = 1'b0; abort = 1'b0;
    wait_idle();

`ifdef LOAD_SEQ_ABORT_EN
    // Abort during HOLD with three entries queued and a push pending
    for (int i = 1; i <= 4; i++) drive_req(i, 3);
    @(negedge clk);
    req_value = 4'd5; req_hold = 4'd0;
    chk("abort_pre_level", level, 3);
    abort = 1'b1;
    #1;
    chk("abort_ready", req_ready, 0);
    @(posedge clk); #3;
    chk("abort_level", level, 0);
    chk("abort_load", load, 0);
    chk("abort_data", data_in, 1);
    @(negedge clk); abort = 1'b0; req_valid = 1'b0;
    n0 = nloads;
    repeat (10) @(posedge clk);
    #3;
    chk("abort_noloads", nloads, n0);
    chk("abort_final_level", level, 0);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/counter_load_sequencer.md
# counter_load_sequencer

Upstream feeder for `counter_load`. It accepts load requests from a producer over a valid/ready handshake, buffers them in a small FIFO, and drives the counter's `load`/`data_in` pair. Each load is a single-cycle pulse, followed by a per-request programmable hold gap. Its `load` and `data_in` outputs connect directly to the `counter_load` ports of the same names.

## Interface
- `WIDTH`, default 4: width of the load value; matches `counter_load` `data_in`.
- `DEPTH`, default 4: request FIFO entries; must be a power of two and at least 2.
- `HOLD_W`, default 4: width of the per-request hold field.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: producer has a request.
- `req_ready` out 1: sequencer can accept a request; equals `!full`.
- `req_value` in WIDTH: value to load into the counter.
- `req_hold` in HOLD_W: idle cycles inserted after this load.
- `load` out 1: load strobe to `counter_load`; registered.
- `data_in` out WIDTH: load value to `counter_load`; registered.
- `busy` out 1: high whenever the FSM is not IDLE or the FIFO is non-empty.
- `level` out $clog2(DEPTH+1): current FIFO occupancy.

## Operation
- **Push:** a request is accepted at a rising edge when `req_valid && req_ready`; `{req_value, req_hold}` is written to the FIFO tail.
- **FSM states:** IDLE, LOAD, HOLD.
- **Decision point:** evaluated in IDLE, in LOAD when the head's hold is 0, and in HOLD on its last cycle.
  - FIFO non-empty: pop the head at that edge and go to LOAD.
  - FIFO empty: go to IDLE.
- **LOAD:** lasts exactly 1 cycle with `load`=1 and `data_in` = popped value. The hold counter is loaded with the popped hold.
  - hold = 0: apply the decision point at the end of LOAD.
  - hold > 0: go to HOLD.
- **HOLD:** lasts exactly `hold` cycles with `load`=0. The counter decrements each cycle; the decision point applies when it reaches 1.
- **Push and pop at the same edge:** both take effect; `level` is unchanged.
- **Full FIFO:** `req_ready`=0 and no push occurs, even if a pop happens at that edge.
- **Empty FIFO:** no pop occurs.
- **Pointers:** wrap modulo DEPTH; no extra entries are lost or duplicated across wrap.
- **`data_in` outside LOAD:** holds the last loaded value; `load` is never high outside LOAD.
- **Reset (any time, including mid-LOAD or mid-HOLD):**
  - State IDLE, FIFO emptied, `level`=0, `busy`=0.
  - `load`=0, `data_in`=0.
  - `req_ready`=1 once reset deasserts.
  - An in-flight pulse is truncated immediately.

## Timing
- **Latency:** a request accepted at edge E0 into an empty, IDLE sequencer is popped at E1. `load`=1 from E1 to E2.
- **Back-to-back:** with hold = 0 and a non-empty FIFO, loads occur on consecutive cycles at one load per cycle.
- **Spacing:** consecutive `load` pulses are separated by exactly `hold` zero cycles of the earlier request.
- **`req_ready`:** combinational from FIFO state only; it does not depend on `req_valid`.
- **`level`, `busy`:** registered; they reflect the state after the most recent edge.

## Configuration
- `LOAD_SEQ_ABORT_EN` defined: adds input port `abort` (1 bit, synchronous).
  - Effect at the next edge: FIFO flushed, state IDLE, `level`=0, `load`=0; `data_in` retains its value.
  - `req_ready` is forced to 0 while `abort`=1, so abort wins over a simultaneous push.
  - Abort during LOAD deasserts `load` at that edge.
- `LOAD_SEQ_ABORT_EN` undefined: no `abort` port; the FIFO empties only by popping or reset.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles, then release. Expect `load`=0, `data_in`=0, `level`=0, `busy`=0, `req_ready`=1.
- **Single request:** push value 9 with hold 0 at edge E0. Expect `load`=1 and `data_in`=9 for exactly the E1–E2 cycle, then `busy`=0.
- **Hold gap:** push {3, hold 2} and {7, hold 0} back-to-back. Expect `load` pattern 1,0,0,1 with `data_in` 3 then 7.
- **Full FIFO and wrap (DEPTH=4):** push 6 requests with hold 3 while draining.
  - Expect `req_ready`=0 at `level`=4, with no push accepted while it is low.
  - Expect all 6 values loaded in order across pointer wrap.
- **Reset mid-operation:** assert `rst` during LOAD with 2 entries still queued. Expect `load`=0 immediately, `level`=0, and no further loads after release.
- **Abort (`LOAD_SEQ_ABORT_EN`):** abort during HOLD with 3 entries queued while `req_valid`=1. Expect the push to be dropped, `level`=0, and no further `load` pulses.
